// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx between NUM_REQ byte producers.
// Define UART_TX_ARB_LOCK_EN to hold the grant on one requester until its req_last byte.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy,
  output logic [1:0]             grant_id,
  output logic                   active,
  output logic [15:0]            bytes_sent,
  output logic                   err_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [1:0]         last_grant;
  logic [7:0]         tmo_cnt;
  logic [NUM_REQ-1:0] elig;
  logic [2:0]         cand;
  logic               win_found;
  logic [1:0]         win_id;
  logic               accept;
  logic               tmo_hit;
  logic               frame_done;
  logic               lock_held;

`ifdef UART_TX_ARB_LOCK_EN
  logic [1:0] lock_id;

  // A byte without req_last pins the grant to its requester; a timeout drop frees it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_held <= 1'b0;
      lock_id   <= '0;
    end else if (accept) begin
      lock_held <= !req_last[win_id];
      lock_id   <= win_id;
    end else if (tmo_hit) begin
      lock_held <= 1'b0;
    end
  end

  always_comb begin
    elig = req_valid;
    if (lock_held) elig = req_valid & (NUM_REQ'(1) << lock_id);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign lock_held   = 1'b0;

  always_comb begin
    elig = req_valid;
  end
`endif

  // Search upward from the requester after the last grant.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 3'(last_grant) + 3'(k);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      if (!win_found && elig[cand[1:0]]) begin
        win_found = 1'b1;
        win_id    = cand[1:0];
      end
    end
  end

  assign tmo_hit    = (state == WAIT_BUSY) && !tx_busy && (tmo_cnt == 8'(BUSY_TIMEOUT - 1));
  assign frame_done = (state == WAIT_DONE) && !tx_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_next = WAIT_DONE;
        else if (tmo_hit) state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // A busy transmitter in IDLE belongs to someone else (or a frame cut off by reset).
  always_comb begin
    accept    = rst_n && (state == IDLE) && !tx_busy && win_found;
    req_ready = accept ? (NUM_REQ'(1) << win_id) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      last_grant  <= 2'(NUM_REQ - 1);
      active      <= 1'b0;
      bytes_sent  <= 16'h0000;
      err_timeout <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      tx_start <= (state_next == START);
      if (accept) begin
        tx_data    <= req_data[8*win_id +: 8];
        grant_id   <= win_id;
        last_grant <= win_id;
        active     <= 1'b1;
      end
      if (state == START)
        tmo_cnt <= '0;
      else if ((state == WAIT_BUSY) && !tx_busy)
        tmo_cnt <= tmo_cnt + 8'd1;
      if (tmo_hit) begin
        err_timeout <= 1'b1;
        active      <= 1'b0;
      end
      if (frame_done) begin
        bytes_sent <= bytes_sent + 16'd1;
        active     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a simple uart_tx busy model.
module tb_uart_tx_arbiter;
  localparam int NR    = 2;
  localparam int FRAME = 6;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            active;
  logic [15:0]     bytes_sent;
  logic            err_timeout;

  logic model_en = 1'b1;
  int   busy_cnt = 0;

  typedef struct {
    int         id;
    logic [7:0] d;
  } exp_t;
  exp_t exp_q[$];

  int nvec = 0;
  int nmis = 0;

  logic [7:0] src_d [NR][4];
  logic       src_l [NR][4];
  int         src_n [NR];
  int         src_i [NR];

  uart_tx_arbiter #(.NUM_REQ(NR), .BUSY_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .active(active),
    .bytes_sent(bytes_sent), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: busy rises the cycle after tx_start and lasts FRAME cycles.
  always @(posedge clk) begin
    if (tx_start && model_en) busy_cnt <= FRAME;
    else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic exp_push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_src();
    for (int r = 0; r < NR; r++) begin
      src_n[r] = 0;
      src_i[r] = 0;
      for (int j = 0; j < 4; j++) begin
        src_d[r][j] = 8'h00;
        src_l[r][j] = 1'b1;
      end
    end
  endtask

  // Monitor: every tx_start must match the next expected grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nmis++;
          $display("FAIL unexpected_start: tx_data 0x%0h grant %0d, want no start", tx_data, grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(e.d));
          chk("grant_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  // Present each source's head byte until 'total' accepts have been seen.
  task automatic run_stream(input int total);
    int acc = 0;
    logic [NR-1:0] rdy;
    for (int n = 0; n < 400 && acc < total; n++) begin
      for (int r = 0; r < NR; r++) begin
        if (src_i[r] < src_n[r]) begin
          req_valid[r]      = 1'b1;
          req_data[8*r +: 8] = src_d[r][src_i[r]];
          req_last[r]       = src_l[r][src_i[r]];
        end else begin
          req_valid[r] = 1'b0;
        end
      end
      #1;
      rdy = req_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy != '0) begin
        chk("ready_onehot", 32'($countones(rdy)), 32'd1);
        for (int r = 0; r < NR; r++) if (rdy[r]) src_i[r]++;
        acc++;
        chk("start_latency", 32'(tx_start), 32'd1);
        chk("ready_pulse", 32'(req_ready), 32'd0);
        chk("active_on_accept", 32'(active), 32'd1);
      end
    end
    req_valid = '0;
    if (acc < total) begin
      nvec++;
      nmis++;
      $display("FAIL accept_timeout: %0d accepts, want %0d", acc, total);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || tx_busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      nvec++;
      nmis++;
      $display("FAIL idle_timeout: active %0b busy %0b, want both 0", active, tx_busy);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_bytes_sent", 32'(bytes_sent), 32'd0);
    chk("rst_err_timeout", 32'(err_timeout), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_src();
    do_reset();

    // Single request from requester 0.
    clear_src();
    src_d[0][0] = 8'hA5; src_n[0] = 1;
    exp_push(0, 8'hA5);
    run_stream(1);
    wait_idle();
    chk("single_bytes_sent", 32'(bytes_sent), 32'd1);
    chk("single_active", 32'(active), 32'd0);
    chk("single_err", 32'(err_timeout), 32'd0);

    // Round robin with both requesters continuously valid.
    do_reset();
    clear_src();
    src_d[0][0] = 8'h11; src_d[0][1] = 8'h11; src_n[0] = 2;
    src_d[1][0] = 8'h22; src_d[1][1] = 8'h22; src_n[1] = 2;
    exp_push(0, 8'h11); exp_push(1, 8'h22); exp_push(0, 8'h11); exp_push(1, 8'h22);
    run_stream(4);
    wait_idle();
    chk("rr_bytes_sent", 32'(bytes_sent), 32'd4);
    chk("rr_last_grant", 32'(grant_id), 32'd1);

    // Transmitter never answers: error after 8 WAIT_BUSY cycles.
    do_reset();
    model_en = 1'b0;
    clear_src();
    src_d[0][0] = 8'h3C; src_n[0] = 1;
    exp_push(0, 8'h3C);
    run_stream(1);
    repeat (8) @(posedge clk);
    #1;
    chk("tmo_err_early", 32'(err_timeout), 32'd0);
    chk("tmo_active_early", 32'(active), 32'd1);
    @(posedge clk);
    #1;
    chk("tmo_err_set", 32'(err_timeout), 32'd1);
    chk("tmo_active_clr", 32'(active), 32'd0);
    chk("tmo_bytes_sent", 32'(bytes_sent), 32'd0);
    model_en = 1'b1;
    @(negedge clk);
    clear_src();
    src_d[1][0] = 8'h5A; src_n[1] = 1;
    exp_push(1, 8'h5A);
    run_stream(1);
    wait_idle();
    chk("tmo_recover_bytes", 32'(bytes_sent), 32'd1);
    chk("tmo_err_sticky", 32'(err_timeout), 32'd1);

    // Reset while the frame is in WAIT_DONE.
    do_reset();
    clear_src();
    src_d[0][0] = 8'h66; src_n[0] = 1;
    exp_push(0, 8'h66);
    run_stream(1);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("mid_busy", 32'(tx_busy), 32'd1);
    chk("mid_active", 32'(active), 32'd1);
    do_reset();
    req_valid[0]   = 1'b1;
    req_data[7:0]  = 8'h77;
    req_last[0]    = 1'b1;
    #1;
    chk("mid_busy_after_rst", 32'(tx_busy), 32'd1);
    chk("mid_stall_ready", 32'(req_ready), 32'd0);
    clear_src();
    src_d[0][0] = 8'h77; src_n[0] = 1;
    exp_push(0, 8'h77);
    run_stream(1);
    wait_idle();
    chk("mid_bytes_sent", 32'(bytes_sent), 32'd1);

    // Packet of three bytes from requester 1 against requester 0.
    do_reset();
    clear_src();
    src_d[0][0] = 8'h01; src_n[0] = 1;
    exp_push(0, 8'h01);
    run_stream(1);
    wait_idle();
    clear_src();
    src_d[0][0] = 8'hB0; src_n[0] = 1;
    src_d[1][0] = 8'hC1; src_l[1][0] = 1'b0;
    src_d[1][1] = 8'hC2; src_l[1][1] = 1'b0;
    src_d[1][2] = 8'hC3; src_l[1][2] = 1'b1;
    src_n[1] = 3;
`ifdef UART_TX_ARB_LOCK_EN
    exp_push(1, 8'hC1); exp_push(1, 8'hC2); exp_push(1, 8'hC3); exp_push(0, 8'hB0);
`else
    exp_push(1, 8'hC1); exp_push(0, 8'hB0); exp_push(1, 8'hC2); exp_push(1, 8'hC3);
`endif
    run_stream(4);
    wait_idle();
    chk("lock_bytes_sent", 32'(bytes_sent), 32'd5);

    // Counter wrap from 0xFFFF.
    @(negedge clk);
    force dut.bytes_sent = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.bytes_sent;
    @(posedge clk);
    @(negedge clk);
    chk("wrap_preload", 32'(bytes_sent), 32'hFFFF);
    clear_src();
    src_d[0][0] = 8'h99; src_n[0] = 1;
    exp_push(0, 8'h99);
    run_stream(1);
    wait_idle();
    chk("wrap_bytes_sent", 32'(bytes_sent), 32'h0000);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
